imem_line_filler: RTL and testbench
===================================

# imem_line_filler

Instruction-side line-fill engine between the L1 instruction cache's miss port and the 32-bit system memory bus. On a cache read request it fetches one aligned 256-bit line as eight single-word bus transactions and assembles it. It returns the line with a one-cycle done pulse. It runs entirely on the posedge of sys_clk, sits directly upstream of the L1 I-cache refill path, and has exactly one fill in flight.

## Interface
- LINE_WORDS, 8, words per line; fixed at 8 for the 256-bit data port.
- ADDR_W, 32, byte-address width.

Ports:
- sys_clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous, active-low reset.
- immu_read  in  1  fill request from the L1 I-cache; sampled only in IDLE.
- immu_addr  in  32  any byte address inside the requested line.
- immu_done  out  1  one-cycle pulse: immu_read_data is valid.
- immu_read_data  out  256  assembled line; word i in bits [32i+31:32i].
- busy  out  1  high in every state except IDLE.
- bus_req_valid  out  1  word read request valid.
- bus_req_ready  in  1  bus accepts the request.
- bus_req_addr  out  32  word-aligned read address.
- bus_rsp_valid  in  1  read data valid; responses are in order, one per accepted request.
- bus_rsp_data  in  32  read data.

## Operation
States are IDLE, REQ, WAIT and DONE.
- **IDLE:** when immu_read=1, latch base = {immu_addr[31:5], 5'b0}, set beat counter idx = start word, and go to REQ.
  - Without the macro, start word = 0.
- **REQ:** bus_req_valid=1 and bus_req_addr = base + 4*word, where word = idx[2:0] (3-bit wrap).
  - On bus_req_valid && bus_req_ready, go to WAIT.
  - bus_req_addr is stable while valid and not accepted.
- **WAIT:** on bus_rsp_valid, write bus_rsp_data into line word slot `word`.
  - Then increment the beat count.
  - After the eighth beat go to DONE; otherwise go to REQ.
  - Idle cycles with no response are legal and unbounded.
- **DONE:** immu_done=1 for exactly one cycle, then go to IDLE.
- bus_rsp_valid outside WAIT is a protocol violation and is ignored; no line slot changes.
- immu_read and immu_addr are ignored outside IDLE.
  - A request dropped mid-fill does not abort the fill.
- The L1 must deassert immu_read in the cycle immu_done is seen. A request still high in the following IDLE cycle starts a new fill.
- immu_read_data holds its value after DONE until slots are overwritten by the next fill.
- Address arithmetic is 32-bit; the line base never crosses a 32-byte boundary, and the word index wraps modulo 8.

## Timing
- Reset values: state=IDLE, immu_done=0, busy=0, bus_req_valid=0, bus_req_addr=0, immu_read_data=0, idx=0.
- Reset mid-fill: the next cycle is IDLE with all outputs at reset values. A later bus response for the aborted fill is ignored.
- Best-case latency applies when ready=1 and the response arrives the cycle after acceptance:
  - Request sampled in IDLE at cycle N.
  - Beat k REQ at N+1+2k, WAIT at N+2+2k.
  - immu_done high during cycle N+17.
  - Next fill can be sampled at N+18.
- Each beat costs 2 cycles plus bus wait cycles. There is no pipelining of requests.

## Configuration
- IMEM_FILL_CWF_EN defined: critical-word-first. The start word is immu_addr[4:2], and the order wraps, e.g. 5,6,7,0,1,2,3,4.
  - immu_done still waits for the full line.
- Not defined: words are fetched in order 0..7 regardless of immu_addr[4:2].
- Cycle counts are identical in both builds.

## Structure
- The shared package holds:
  - the state enum (IDLE, REQ, WAIT, DONE);
  - LINE_BYTES=32 and LINE_WORDS=8;
  - OFFSET_BITS=5 and WORD_IDX_BITS=3;
  - a line-base helper function (clear low 5 bits).
- No sub-module; FSM, counter and line register live in a single module.

## Test plan
- **Reset/idle:** rst_n=0 for 2 cycles, then idle → all outputs at 0 and busy=0; a bus_rsp_valid pulse in IDLE leaves immu_read_data=0.
- **Basic fill:** immu_addr=0x0000_1234, memory word = address, ready=1, 1-cycle response.
  - → bus addresses 0x1220..0x123C in order.
  - → immu_done at N+17.
  - → word i = 0x1220+4i.
- **Back-pressure:** as above, but ready low for 3 cycles on beat 2 and the response delayed 4 cycles on beat 6 → same data; done at N+17+3+3.
- **CWF (macro on):** immu_addr=0x0000_1234 → address order 0x1234, 0x1238, 0x123C, 0x1220, …, 0x1230 → line identical to the basic-fill result.
- **Request handling:** immu_read dropped after 1 cycle → fill still completes with done. immu_read held high after done → second fill starts at N+18, busy rises at N+19.
- **Reset mid-fill:** assert rst_n=0 during beat 4 WAIT → IDLE next cycle, no done pulse, stray response ignored; a new fill from 0x0000_8000 completes correctly.

Source files
------------

// File: rtl/imem_line_filler_pkg.sv
`default_nettype none
// ============================================================================
//  imem_line_filler_pkg
//  Shared definitions for the instruction-side line-fill engine.
//
//  Contents:
//    fill_state_t  : FSM states (IDLE, REQ, WAIT, DONE)
//    ADDR_W        : byte-address width (32)
//    LINE_BYTES    : bytes per cache line (32)
//    LINE_WORDS    : 32-bit words per cache line (8)
//    OFFSET_BITS   : byte-offset bits inside a line (5)
//    WORD_IDX_BITS : word-index bits inside a line (3)
//    line_base()   : clears the in-line byte offset of an address
//
//  Revision: 1.0  initial release
// ============================================================================
package imem_line_filler_pkg;

  localparam int ADDR_W        = 32;
  localparam int LINE_BYTES    = 32;
  localparam int LINE_WORDS    = 8;
  localparam int OFFSET_BITS   = 5;
  localparam int WORD_IDX_BITS = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } fill_state_t;

  // Aligned base address of the line containing addr.
  function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

endpackage : imem_line_filler_pkg
`default_nettype wire

// File: rtl/imem_line_filler.sv
`default_nettype none
// ============================================================================
//  imem_line_filler
//  Instruction-side line-fill engine. On an L1 I-cache miss it fetches one
//  aligned 256-bit line as eight single-word reads on the 32-bit system bus,
//  assembles the line and returns it with a one-cycle done pulse. Exactly one
//  fill is in flight at a time; requests are not pipelined.
//
//  Ports:
//    sys_clk        in   1    clock, all state on posedge
//    rst_n          in   1    synchronous, active-low reset
//    immu_read      in   1    fill request, sampled only in IDLE
//    immu_addr      in   32   any byte address inside the requested line
//    immu_done      out  1    one-cycle pulse, immu_read_data valid
//    immu_read_data out  256  assembled line, word i in [32i+31:32i]
//    busy           out  1    high in every state except IDLE
//    bus_req_valid  out  1    word read request valid
//    bus_req_ready  in   1    bus accepts the request
//    bus_req_addr   out  32   word-aligned read address
//    bus_rsp_valid  in   1    read data valid (in order, one per request)
//    bus_rsp_data   in   32   read data
//
//  Build option:
//    IMEM_FILL_CWF_EN  critical-word-first: the fill starts at the word
//                      addressed by immu_addr[4:2] and wraps around the
//                      line. Undefined: words are fetched 0..7.
//
//  Revision: 1.0  initial release
// ============================================================================
module imem_line_filler
  import imem_line_filler_pkg::*;
(
  input  logic                     sys_clk,
  input  logic                     rst_n,
  input  logic                     immu_read,
  input  logic [ADDR_W-1:0]        immu_addr,
  output logic                     immu_done,
  output logic [LINE_WORDS*32-1:0] immu_read_data,
  output logic                     busy,
  output logic                     bus_req_valid,
  input  logic                     bus_req_ready,
  output logic [ADDR_W-1:0]        bus_req_addr,
  input  logic                     bus_rsp_valid,
  input  logic [31:0]              bus_rsp_data
);

  fill_state_t state;
  fill_state_t state_nx;

  logic [ADDR_W-1:0]        base;        // aligned line base of current fill
  logic [WORD_IDX_BITS-1:0] idx;         // word slot of the current beat
  logic [WORD_IDX_BITS-1:0] beat;        // beats completed so far
  logic [WORD_IDX_BITS-1:0] start_word;  // first word slot of a new fill
  logic [31:0]              words [LINE_WORDS];

  logic accept_req;
  logic take_rsp;
  logic last_beat;

  // --------------------------------------------------------------------------
  // Start word selection
  // --------------------------------------------------------------------------
`ifdef IMEM_FILL_CWF_EN
  assign start_word = immu_addr[OFFSET_BITS-1:2];
`else
  assign start_word = '0;
`endif

  // The byte offset only matters for the start word (CWF build); the two
  // byte-lane bits never matter since every bus access is a full word.
  logic unused_addr_offset;
  assign unused_addr_offset = ^immu_addr[OFFSET_BITS-1:0];

  // --------------------------------------------------------------------------
  // Handshake qualifiers
  // --------------------------------------------------------------------------
  assign accept_req = (state == REQ)  && bus_req_ready;
  // Responses outside WAIT are protocol violations and are dropped here.
  assign take_rsp   = (state == WAIT) && bus_rsp_valid;
  // The beat counter wraps, so "eighth beat" is the response taken with
  // beat == 7; the counter is independent of the (possibly rotated) slot.
  assign last_beat  = (beat == WORD_IDX_BITS'(LINE_WORDS - 1));

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (immu_read) begin
          state_nx = REQ;
        end
      end
      REQ: begin
        if (accept_req) begin
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (take_rsp) begin
          state_nx = last_beat ? DONE : REQ;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Fill datapath: line base, word pointer, beat count, line register
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      base <= '0;
      idx  <= '0;
      beat <= '0;
      for (int i = 0; i < LINE_WORDS; i++) begin
        words[i] <= '0;
      end
    end else begin
      if ((state == IDLE) && immu_read) begin
        base <= line_base(immu_addr);
        idx  <= start_word;
        beat <= '0;
      end else if (take_rsp) begin
        words[idx] <= bus_rsp_data;
        // 3-bit wrap keeps the CWF order inside the line.
        idx        <= idx + WORD_IDX_BITS'(1);
        beat       <= beat + WORD_IDX_BITS'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // base has its low five bits clear, so OR-ing the word offset is an add that
  // can never carry out of the line. Built only from registers, so the address
  // is stable for as long as the request waits for ready.
  assign bus_req_addr  = base | ADDR_W'({idx, 2'b00});
  assign bus_req_valid = (state == REQ);
  assign immu_done     = (state == DONE);
  assign busy          = (state != IDLE);

  for (genvar g = 0; g < LINE_WORDS; g++) begin : g_pack_line
    assign immu_read_data[32*g +: 32] = words[g];
  end

endmodule : imem_line_filler
`default_nettype wire

// File: tb/tb_imem_line_filler.sv
`default_nettype none
// ============================================================================
//  tb_imem_line_filler
//  Self-checking bench for imem_line_filler. A behavioural model derives the
//  expected bus address order and the assembled line from the fill address
//  and a keyed memory image; the bench plays the bus side cycle by cycle.
//  Honors IMEM_FILL_CWF_EN for the expected word order.
//
//  Revision: 1.0  initial release
// ============================================================================
module tb_imem_line_filler;

  logic         sys_clk;
  logic         rst_n;
  logic         immu_read;
  logic [31:0]  immu_addr;
  logic         immu_done;
  logic [255:0] immu_read_data;
  logic         busy;
  logic         bus_req_valid;
  logic         bus_req_ready;
  logic [31:0]  bus_req_addr;
  logic         bus_rsp_valid;
  logic [31:0]  bus_rsp_data;

  int           n_total = 0;
  int           n_pass  = 0;
  int           cyc     = 0;
  logic [31:0]  mem_key = 32'h0;
  int           stall_cfg [8];
  int           delay_cfg [8];

  imem_line_filler dut (
    .sys_clk        (sys_clk),
    .rst_n          (rst_n),
    .immu_read      (immu_read),
    .immu_addr      (immu_addr),
    .immu_done      (immu_done),
    .immu_read_data (immu_read_data),
    .busy           (busy),
    .bus_req_valid  (bus_req_valid),
    .bus_req_ready  (bus_req_ready),
    .bus_req_addr   (bus_req_addr),
    .bus_rsp_valid  (bus_rsp_valid),
    .bus_rsp_data   (bus_rsp_data)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Memory image seen by the bus: a keyed function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ mem_key;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < 8; i++) begin
      stall_cfg[i] = 0;
      delay_cfg[i] = 0;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_done"},  256'(immu_done),      256'(0));
    chk({tag, "_busy"},  256'(busy),           256'(0));
    chk({tag, "_valid"}, 256'(bus_req_valid),  256'(0));
    chk({tag, "_addr"},  256'(bus_req_addr),   256'(0));
    chk({tag, "_data"},  immu_read_data,       256'(0));
  endtask

  // Runs one fill starting at a negedge in IDLE; returns at the negedge of the
  // IDLE cycle after DONE (or right after a mid-fill reset when abort_beat hits).
  task automatic do_fill(input logic [31:0] addr, input bit drop_read,
                         input bit keep_read, input int abort_beat);
    logic [31:0]  base;
    logic [31:0]  a;
    logic [255:0] exp_line;
    int           start;
    int           w;
    base = {addr[31:5], 5'b0};
`ifdef IMEM_FILL_CWF_EN
    start = int'(addr[4:2]);
`else
    start = 0;
`endif
    exp_line = '0;
    for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = mem_word(base + 32'(4*i));

    chk("idle_busy", 256'(busy), 256'(0));
    immu_read = 1'b1;
    immu_addr = addr;
    @(negedge sys_clk);
    chk("busy_rise", 256'(busy), 256'(1));
    if (drop_read) immu_read = 1'b0;

    for (int k = 0; k < 8; k++) begin
      w = (start + k) % 8;
      a = base + 32'(4*w);
      for (int s = 0; s < stall_cfg[k]; s++) begin
        bus_req_ready = 1'b0;
        chk($sformatf("stall_valid_b%0d", k), 256'(bus_req_valid), 256'(1));
        chk($sformatf("stall_addr_b%0d", k),  256'(bus_req_addr),  256'(a));
        @(negedge sys_clk);
      end
      bus_req_ready = 1'b1;
      chk($sformatf("req_valid_b%0d", k), 256'(bus_req_valid), 256'(1));
      chk($sformatf("req_addr_b%0d", k),  256'(bus_req_addr),  256'(a));
      chk($sformatf("req_done_b%0d", k),  256'(immu_done),     256'(0));
      @(negedge sys_clk);
      chk($sformatf("wait_valid_b%0d", k), 256'(bus_req_valid), 256'(0));
      chk($sformatf("wait_busy_b%0d", k),  256'(busy),          256'(1));
      if (k == abort_beat) begin
        rst_n     = 1'b0;
        immu_read = 1'b0;
        @(negedge sys_clk);
        chk_reset_outputs("midrst");
        rst_n         = 1'b1;
        bus_rsp_valid = 1'b1;
        bus_rsp_data  = mem_word(a);
        @(negedge sys_clk);
        bus_rsp_valid = 1'b0;
        chk("stray_data", immu_read_data,   256'(0));
        chk("stray_busy", 256'(busy),       256'(0));
        chk("stray_done", 256'(immu_done),  256'(0));
        return;
      end
      for (int d = 0; d < delay_cfg[k]; d++) begin
        bus_rsp_valid = 1'b0;
        @(negedge sys_clk);
        chk($sformatf("delay_valid_b%0d", k), 256'(bus_req_valid), 256'(0));
      end
      bus_rsp_valid = 1'b1;
      bus_rsp_data  = mem_word(a);
      @(negedge sys_clk);
      bus_rsp_valid = 1'b0;
      bus_rsp_data  = $urandom;
    end

    chk("done_pulse", 256'(immu_done),     256'(1));
    chk("done_valid", 256'(bus_req_valid), 256'(0));
    chk("done_line",  immu_read_data,      exp_line);
    if (!keep_read) immu_read = 1'b0;
    @(negedge sys_clk);
    chk("post_done",  256'(immu_done), 256'(0));
    chk("post_busy",  256'(busy),      256'(0));
    chk("post_hold",  immu_read_data,  exp_line);
  endtask

  initial begin
    rst_n         = 1'b0;
    immu_read     = 1'b0;
    immu_addr     = 32'h0;
    bus_req_ready = 1'b1;
    bus_rsp_valid = 1'b0;
    bus_rsp_data  = 32'h0;
    clear_cfg();

    // Reset and idle behaviour
    repeat (2) @(negedge sys_clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge sys_clk);
    chk_reset_outputs("idle");
    bus_rsp_valid = 1'b1;
    bus_rsp_data  = 32'hDEAD_BEEF;
    @(negedge sys_clk);
    bus_rsp_valid = 1'b0;
    chk("idle_rsp_data", immu_read_data, 256'(0));

    // Basic fill, memory word = address
    mem_key = 32'h0;
    clear_cfg();
    do_fill(32'h0000_1234, 1'b0, 1'b0, -1);

    // Back-pressure: ready low 3 cycles on beat 2, response 4 cycles late on beat 6
    clear_cfg();
    stall_cfg[2] = 3;
    delay_cfg[6] = 3;
    do_fill(32'h0000_1234, 1'b0, 1'b0, -1);

    // Request dropped after one cycle still completes
    clear_cfg();
    mem_key = 32'h5A5A_0F0F;
    do_fill(32'h0000_4C08, 1'b1, 1'b0, -1);

    // Request held through done: second fill starts in the following IDLE cycle
    do_fill(32'h0001_0010, 1'b0, 1'b1, -1);
    do_fill(32'h0002_003C, 1'b0, 1'b0, -1);

    // Reset during beat 4 WAIT, then a clean fill from 0x8000
    do_fill(32'h0000_3004, 1'b0, 1'b0, 4);
    mem_key = 32'h0;
    do_fill(32'h0000_8000, 1'b0, 1'b0, -1);

    // Randomized fills with random stalls and response delays
    for (int r = 0; r < 6; r++) begin
      mem_key = $urandom;
      for (int i = 0; i < 8; i++) begin
        stall_cfg[i] = $urandom_range(0, 3);
        delay_cfg[i] = $urandom_range(0, 3);
      end
      do_fill($urandom, 1'($urandom_range(0, 1)), 1'b0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_imem_line_filler
`default_nettype wire
